// File: rtl/jam_cost_feeder.sv
// Cost-matrix feeder and result collector for the 8x8 job-assignment solver.
// Ping-pong banks are filled from a ready/valid stream; results leave tagged with a problem id.
module jam_cost_feeder #(
    parameter int COST_W = 7,
    parameter int ID_W   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_data,
    input  logic              in_last,
    output logic              frame_err,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    output logic              SOLV_RST,
    input  logic              sol_valid,
    input  logic [9:0]        sol_mincost,
    input  logic [3:0]        sol_matchcount,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [9:0]        res_mincost,
    output logic [3:0]        res_matchcount,
    output logic [ID_W-1:0]   res_id
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state, state_nx;
    logic [COST_W-1:0] bank [2][64];
    logic [1:0]        full;
    logic              wr_bank, rd_bank;
    logic [5:0]        count;
    logic [ID_W-1:0]   id_cnt;
    logic              accept, commit, capture;

    assign in_ready = !RST && !full[wr_bank];
    assign accept   = in_valid && in_ready;
    assign commit   = accept && (count == 6'd63);
    assign Cost     = bank[rd_bank][{W, J}];

    always_ff @(posedge CLK) begin
        if (accept)
            bank[wr_bank][count] <= in_data;
    end

    // A 64th beat always commits; a missing or early in_last only raises frame_err.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_bank   <= 1'b0;
            count     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (accept) begin
                if (count == 6'd63) begin
                    count     <= '0;
                    wr_bank   <= ~wr_bank;
                    frame_err <= !in_last;
                end else if (in_last) begin
                    count     <= '0;
                    frame_err <= 1'b1;
                end else begin
                    count <= count + 6'd1;
                end
            end
        end
    end

    // Writer and sequencer never address the same bank in one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            full <= '0;
        end else begin
            if (commit)
                full[wr_bank] <= 1'b1;
            if (capture)
                full[rd_bank] <= 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        case (state)
            S_IDLE: begin
                if (full[rd_bank])
                    state_nx = S_RUN;
            end
            S_RUN: begin
                if (sol_valid && (!res_valid || res_ready)) begin
                    capture  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= S_IDLE;
            SOLV_RST       <= 1'b1;
            rd_bank        <= 1'b0;
            id_cnt         <= '0;
            res_valid      <= 1'b0;
            res_mincost    <= '0;
            res_matchcount <= '0;
            res_id         <= '0;
        end else begin
            state    <= state_nx;
            SOLV_RST <= (state_nx == S_IDLE);
            if (capture) begin
                rd_bank        <= ~rd_bank;
                id_cnt         <= id_cnt + ID_W'(1);
                res_valid      <= 1'b1;
                res_mincost    <= sol_mincost;
                res_matchcount <= sol_matchcount;
                res_id         <= id_cnt;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jam_cost_feeder.sv
// Self-checking bench for jam_cost_feeder: a behavioural solver reads the matrix through W/J,
// and expected results come from a brute-force assignment model of each matrix sent.
module tb_jam_cost_feeder;

    typedef logic [6:0] mat_t [64];
    typedef struct {
        int mc;
        int cnt;
        int id;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       frame_err;
    logic [2:0] W = '0;
    logic [2:0] J = '0;
    logic [6:0] Cost;
    logic       SOLV_RST;
    logic       sol_valid = 1'b0;
    logic [9:0] sol_mincost = '0;
    logic [3:0] sol_matchcount = '0;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [9:0] res_mincost;
    logic [3:0] res_matchcount;
    logic [7:0] res_id;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   next_id = 0;
    int   fe_count = 0;
    int   run_cycles = 0;
    int   ncap = 0;

    jam_cost_feeder #(.COST_W(7), .ID_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .frame_err(frame_err), .W(W), .J(J), .Cost(Cost), .SOLV_RST(SOLV_RST),
        .sol_valid(sol_valid), .sol_mincost(sol_mincost), .sol_matchcount(sol_matchcount),
        .res_valid(res_valid), .res_ready(res_ready), .res_mincost(res_mincost),
        .res_matchcount(res_matchcount), .res_id(res_id)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Minimum total cost over all 8! assignments and how many reach it (saturating at 15).
    function automatic void brute(input mat_t mm, output int best, output int cnt);
        int p[8];
        int s, i, j, t, a, b;
        bit done;
        best = 32'h7fffffff;
        cnt  = 0;
        done = 1'b0;
        for (int q = 0; q < 8; q++) p[q] = q;
        while (!done) begin
            s = 0;
            for (int w = 0; w < 8; w++) s += int'(mm[w*8 + p[w]]);
            if (s < best) begin
                best = s;
                cnt  = 1;
            end else if (s == best && cnt < 15) begin
                cnt++;
            end
            i = 6;
            while (i >= 0 && p[i] > p[i+1]) i--;
            if (i < 0) begin
                done = 1'b1;
            end else begin
                j = 7;
                while (p[j] < p[i]) j--;
                t = p[i]; p[i] = p[j]; p[j] = t;
                a = i + 1; b = 7;
                while (a < b) begin
                    t = p[a]; p[a] = p[b]; p[b] = t;
                    a++; b--;
                end
            end
        end
    endfunction

    // Behavioural solver: walks all 64 cells via W/J on falling edges, then holds Valid.
    int   sidx = 0;
    int   sdelay = 0;
    mat_t smat;
    always @(negedge CLK) begin
        int b, c;
        if (SOLV_RST === 1'b1) begin
            sidx      = 0;
            sdelay    = $urandom_range(0, 4);
            sol_valid = 1'b0;
            {W, J}    = 6'd0;
        end else if (sidx < 64) begin
            smat[sidx] = Cost;
            sidx++;
            {W, J} = sidx[5:0];
        end else if (!sol_valid) begin
            if (sdelay == 0) begin
                brute(smat, b, c);
                sol_mincost    = b[9:0];
                sol_matchcount = c[3:0];
                sol_valid      = 1'b1;
            end else begin
                sdelay--;
            end
        end
    end

    // Result monitor: scoreboard pops, hold stability and SOLV_RST at each new capture.
    logic       prev_valid = 1'b0;
    logic       prev_acc = 1'b0;
    logic [21:0] prev_fields = '0;
    always begin
        exp_t e;
        @(negedge CLK);
        #1;
        if (RST) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (frame_err === 1'b1) fe_count++;
            if (SOLV_RST === 1'b0) run_cycles++;
            if (res_valid === 1'b1 && (!prev_valid || prev_acc)) begin
                ncap++;
                check("solv_rst_at_capture", SOLV_RST, 1);
            end else if (res_valid === 1'b1 && prev_valid && !prev_acc) begin
                check("res_hold", {res_mincost, res_matchcount, res_id}, prev_fields);
            end
            if (res_valid === 1'b1 && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", res_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_mincost", res_mincost, e.mc);
                    check("res_matchcount", res_matchcount, e.cnt);
                    check("res_id", res_id, e.id);
                end
            end
            prev_valid  = (res_valid === 1'b1);
            prev_acc    = (res_valid === 1'b1) && res_ready;
            prev_fields = {res_mincost, res_matchcount, res_id};
        end
    end

    task automatic push_exp(input mat_t mm);
        int b, c;
        brute(mm, b, c);
        exp_q.push_back('{b, c, next_id});
        next_id = (next_id + 1) % 256;
    endtask

    task automatic rand_mat(output mat_t mm);
        for (int n = 0; n < 64; n++) mm[n] = 7'($urandom_range(0, 127));
    endtask

    task automatic send_beat(input logic [6:0] d, input logic l, output int st);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        st = 0;
        while (in_ready !== 1'b1 && st < 2000) begin
            @(negedge CLK);
            st++;
        end
        if (st >= 2000) check("beat_timeout", in_ready, 1);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic send_frame(input mat_t mm, input int nb, input int last_at, output int tot);
        int s;
        tot = 0;
        for (int n = 0; n < nb; n++) begin
            send_beat(mm[n], n == last_at, s);
            tot += s;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || res_valid !== 1'b0) && n < 1500) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_cap(input int target, input string tag);
        int n = 0;
        while (ncap < target && n < 500) begin
            @(negedge CLK);
            n++;
        end
        check(tag, ncap, target);
    endtask

    initial begin
        mat_t m, m2, m3, g;
        int   s, s1, s2, n, fe0, run0, cap0, id0;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_in_ready", in_ready, 0);
        check("rst_solv_rst", SOLV_RST, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_fields", {res_mincost, res_matchcount, res_id}, 0);
        check("rst_frame_err", frame_err, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_solv_rst", SOLV_RST, 1);

        // Diagonal matrix: min 8, unique optimum
        for (int n2 = 0; n2 < 64; n2++) m[n2] = (n2 / 8 == n2 % 8) ? 7'd1 : 7'd20;
        run0 = run_cycles;
        push_exp(m);
        send_frame(m, 64, 63, s);
        idle();
        wait_done("t1_done");
        check("t1_solv_rst_fell", run_cycles > run0, 1);

        // Two matrices back-to-back, then a stalled 129th beat
        for (int n2 = 0; n2 < 64; n2++) m[n2] = 7'(((n2 / 8) + (n2 % 8)) % 8 + 1);
        id0 = next_id;
        push_exp(m);
        push_exp(m);
        push_exp(m);
        send_frame(m, 64, 63, s1);
        send_frame(m, 64, 63, s2);
        check("t2_no_stall", s1 + s2, 0);
        in_valid = 1'b1;
        in_data  = m[0];
        in_last  = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        check("t2_beat129_stalled", n > 0, 1);
        check("t2_free_res_valid", res_valid, 1);
        check("t2_free_res_id", res_id, id0);
        @(posedge CLK);
        @(negedge CLK);
        for (int n2 = 1; n2 < 64; n2++) begin
            send_beat(m[n2], n2 == 63, s);
        end
        idle();
        wait_done("t2_done");

        // Result back-pressure keeps the second solve parked in RUN
        res_ready = 1'b0;
        rand_mat(m);
        rand_mat(m2);
        id0  = next_id;
        cap0 = ncap;
        push_exp(m);
        push_exp(m2);
        send_frame(m, 64, 63, s);
        send_frame(m2, 64, 63, s);
        idle();
        wait_cap(cap0 + 1, "t3_first_capture");
        repeat (120) @(negedge CLK);
        check("t3_run_solv_rst", SOLV_RST, 0);
        check("t3_held_valid", res_valid, 1);
        check("t3_held_id", res_id, id0);
        check("t3_no_second_capture", ncap, cap0 + 1);
        rand_mat(m3);
        push_exp(m3);
        send_frame(m3, 64, 63, s);
        idle();
        repeat (3) @(negedge CLK);
        check("t3_bank_locked", in_ready, 0);
        res_ready = 1'b1;
        @(negedge CLK);
        check("t3_second_valid", res_valid, 1);
        check("t3_second_id", res_id, (id0 + 1) % 256);
        wait_done("t3_done");

        // Early in_last on beat 10 discards the partial frame
        fe0 = fe_count;
        rand_mat(g);
        rand_mat(m);
        push_exp(m);
        send_frame(g, 10, 9, s);
        check("t4_in_ready_after_early", in_ready, 1);
        send_frame(m, 64, 63, s);
        idle();
        wait_done("t4_done");
        check("t4_frame_err_once", fe_count, fe0 + 1);

        // Missing in_last on the 64th beat still commits
        fe0 = fe_count;
        rand_mat(m);
        push_exp(m);
        send_frame(m, 64, -1, s);
        idle();
        wait_done("t5_done");
        check("t5_frame_err_once", fe_count, fe0 + 1);

        // Reset mid-load
        rand_mat(g);
        send_frame(g, 30, -1, s);
        RST = 1'b1;
        #1;
        check("t6_load_rst_in_ready", in_ready, 0);
        @(negedge CLK);
        idle();
        check("t6_load_rst_solv_rst", SOLV_RST, 1);
        check("t6_load_rst_res_valid", res_valid, 0);
        exp_q.delete();
        next_id = 0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Reset mid-RUN with a result still pending
        res_ready = 1'b0;
        rand_mat(m);
        rand_mat(m2);
        cap0 = ncap;
        push_exp(m);
        push_exp(m2);
        send_frame(m, 64, 63, s);
        send_frame(m2, 64, 63, s);
        idle();
        wait_cap(cap0 + 1, "t6_run_capture");
        repeat (10) @(negedge CLK);
        check("t6_in_run", SOLV_RST, 0);
        RST = 1'b1;
        #1;
        check("t6_run_rst_in_ready", in_ready, 0);
        @(negedge CLK);
        check("t6_run_rst_solv_rst", SOLV_RST, 1);
        check("t6_run_rst_res_valid", res_valid, 0);
        check("t6_run_rst_fields", {res_mincost, res_matchcount, res_id}, 0);
        exp_q.delete();
        next_id = 0;
        @(negedge CLK);
        RST = 1'b0;
        res_ready = 1'b1;
        @(negedge CLK);

        // Clean load after reset restarts ids at 0
        fe0 = fe_count;
        rand_mat(m);
        push_exp(m);
        send_frame(m, 64, 63, s);
        idle();
        wait_done("t6_clean_done");
        check("t6_clean_no_frame_err", fe_count, fe0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jam_cost_feeder.md
Name: jam_cost_feeder

Overview:
- Upstream feeder and result collector for the 8x8 job-assignment solver.
- Accepts cost matrices as a ready/valid stream of 64 row-major 7-bit costs into two ping-pong register banks.
- Serves the solver's combinational W/J cost lookups from the active bank and sequences the solver through per-problem reset.
- Captures each solver result (MinCost, MatchCount) into a ready/valid result port tagged with a problem id.

Parameters:
- COST_W, 7, width of one cost entry (solver port width; only value supported).
- ID_W, 8, width of the problem-id counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset; synchronous, active-high
- in_valid  in  1  cost beat valid
- in_ready  out  1  feeder can accept a beat
- in_data  in  COST_W  cost beat; beat n is entry [n/8][n%8]
- in_last  in  1  marks 64th beat of a matrix
- frame_err  out  1  one-cycle pulse on framing error
- W  in  3  solver worker index
- J  in  3  solver job index
- Cost  out  COST_W  cost[W][J] of read bank, combinational
- SOLV_RST  out  1  solver synchronous reset, registered
- sol_valid  in  1  solver Valid (level, held until solver reset)
- sol_mincost  in  10  solver MinCost
- sol_matchcount  in  4  solver MatchCount
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_mincost  out  10  captured MinCost
- res_matchcount  out  4  captured MatchCount
- res_id  out  ID_W  sequence number of the problem

Behaviour:
- Reset state:
  - Bank full flags = 0, wr_bank = rd_bank = 0, beat count = 0.
  - SOLV_RST = 1, res_valid = 0, res_mincost/res_matchcount/res_id = 0, id counter = 0, frame_err = 0.
  - Bank contents are not reset.
  - in_ready = 0 while RST is high.
- Writer:
  - in_ready = !RST && !full[wr_bank], from registered flags only.
  - A beat is accepted on a rising edge with in_valid && in_ready.
  - It is written to bank[wr_bank][count], then count increments.
- Commit, normal: accepted beat with count==63 sets full[wr_bank], toggles wr_bank, and clears count.
  - If in_last is low on that beat, the bank still commits and frame_err pulses.
- Early in_last: in_last on a beat with count<63 pulses frame_err, clears count, and leaves the bank empty; partial data is discarded.
- Lookup: Cost = bank[rd_bank][{W,J}], a pure combinational read with no latency.
  - The solver samples Cost on its falling edge.
- Sequencer FSM:
  - IDLE: SOLV_RST=1. If full[rd_bank], go to RUN; SOLV_RST=0 from the next cycle.
    - IDLE always lasts at least 1 cycle, so the solver sees at least one reset edge.
  - RUN: SOLV_RST=0. When sol_valid && (!res_valid || res_ready):
    - Capture sol_mincost, sol_matchcount and the id counter into the res registers; set res_valid=1.
    - Increment the id counter (wraps 2^ID_W-1 -> 0).
    - Clear full[rd_bank] and toggle rd_bank.
    - Set SOLV_RST=1 and go to IDLE.
  - RUN with sol_valid && res_valid && !res_ready: stay in RUN. The solver holds Valid and the bank stays locked.
- Result port:
  - res_valid clears on res_ready unless a new capture happens in the same cycle; the capture wins.
  - Held fields stay stable while res_valid && !res_ready.
- Timing and simultaneous events:
  - A bank freed at edge k is writable from edge k+1 (in_ready rises after k).
  - A bank committed at edge k is seen by IDLE at edge k+1.
  - Writer and sequencer never target the same bank in one cycle. The bank the sequencer frees can only be the bank the writer is waiting on (or the other bank if that one is empty).
- Reset mid-operation: everything returns to reset state within one edge, including in-flight partial frames and pending results. SOLV_RST=1 during RST.

Test Plan:
- Single matrix, cost[w][j]=1 if w==j else 20, in_last on beat 64: SOLV_RST falls, then res_valid with res_mincost=8, res_matchcount=1, res_id=0; SOLV_RST=1 within 1 cycle of capture.
- cost[w][j]=(w+j)%8+1 loaded twice back-to-back with in_valid held: 128 beats accepted without stall; 129th beat stalls (in_ready=0) until first result captured, then accepted the cycle after the free; results carry res_id 0, 1.
- res_ready held low after first result: second solve finishes, FSM stays in RUN with SOLV_RST=0, bank locked. Raise res_ready → second result captured on the same edge as first is accepted; res_id=1.
- in_last asserted on beat 10: frame_err pulses once, in_ready stays 1, next 64 beats form the matrix; result correct.
- 64 beats without in_last: frame_err pulse on beat 64; matrix still solved normally.
- RST asserted mid-load (beat 30) and again mid-RUN: SOLV_RST=1, res_valid=0, in_ready=0 during RST; a subsequent clean load gives res_id=0 and the correct result.
